// File: rtl/cp0_interrupt_unit.sv
//------------------------------------------------------------------------------
// cp0_interrupt_unit
//
// Coprocessor-0 interrupt receiver. Up to eight level-sensitive request lines
// are registered and then loaded into Cause.IP. They are gated by Status.IM,
// Status.IE and Status.EXL to decide whether an interrupt is taken. On a take
// the unit sets EXL, captures the resume PC into EPC and clears ExcCode. `eret`
// clears EXL. `mtc0` writes Status and EPC.
//
// Ports
//   clock           rising-edge system clock
//   reset           asynchronous, active-low reset
//   irq[NIRQ-1:0]   level interrupt requests (bit 7 = TimerInterrupt)
//   regnum[4:0]     CP0 register select for mfc0 / mtc0
//   wr_data[31:0]   mtc0 write data
//   MTC0            write wr_data into register regnum
//   ERET            return from exception (clears EXL)
//   stall           pipeline stall; blocks take, MTC0 and ERET, not IP sampling
//   next_pc[31:0]   resume PC, captured into EPC on a take
//   rd_data[31:0]   combinational mfc0 read of register regnum
//   EPC[31:0]       current EPC register
//   TakenInterrupt  an interrupt is taken this cycle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module cp0_interrupt_unit #(
  parameter int NIRQ = 8          // 1..8; line i maps to Cause/Status bit 8+i
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq,
  input  logic [4:0]      regnum,
  input  logic [31:0]     wr_data,
  input  logic            MTC0,
  input  logic            ERET,
  input  logic            stall,
  input  logic [31:0]     next_pc,
  output logic [31:0]     rd_data,
  output logic [31:0]     EPC,
  output logic            TakenInterrupt
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  // Architectural and sampling state
  logic [NIRQ-1:0] r_irq_q;     // first-stage register of the raw request lines
  logic [NIRQ-1:0] r_ip;        // Cause.IP
  logic [NIRQ-1:0] r_im;        // Status.IM
  logic            r_exl;       // Status.EXL
  logic            r_ie;        // Status.IE
  logic [4:0]      r_exccode;   // Cause.ExcCode (interrupts only ever write 0)
  logic [31:0]     r_epc;

  // Qualified control and read-back views
  logic            w_take;
  logic            w_eret;
  logic            w_mtc0;
  logic [7:0]      w_ip8;
  logic [7:0]      w_im8;
  logic [31:0]     w_status;
  logic [31:0]     w_cause;

  // Zero-extend to the full 8-bit field so unused lines read as 0 for NIRQ<8.
  assign w_ip8 = 8'(r_ip);
  assign w_im8 = 8'(r_im);

  assign w_status = {16'h0000, w_im8, 6'b000000, r_exl, r_ie};
  assign w_cause  = {16'h0000, w_ip8, 1'b0, r_exccode, 2'b00};

  // The take is a function of registered state and stall only, so a glitch on
  // irq can never reach the datapath redirect in the same cycle. Because EXL
  // is set on the take edge, the pulse lasts exactly one cycle.
  assign w_take = (|(r_ip & r_im)) & r_ie & ~r_exl & ~stall;

  // A take squashes the instruction in flight, so its ERET/MTC0 must not land.
  assign w_eret = ERET & ~stall & ~w_take;
  assign w_mtc0 = MTC0 & ~stall & ~w_take & ~ERET;

  assign TakenInterrupt = w_take;
  assign EPC            = r_epc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain r_irq_q into r_ip
  // within one edge and lose a stage of latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_irq_q   <= '0;
      r_ip      <= '0;
      r_im      <= '0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_exccode <= '0;
      r_epc     <= '0;
    end else begin
      // IP sampling runs every cycle, independent of stall and of the take.
      r_irq_q <= irq;
      r_ip    <= r_irq_q;

      if (w_take) begin
        r_exl     <= 1'b1;
        r_epc     <= next_pc;
        r_exccode <= '0;
      end else if (w_eret) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        // Cause is read-only from software; writes to it fall through here.
        if (regnum == REG_STATUS) begin
          r_im  <= wr_data[8 +: NIRQ];
          r_exl <= wr_data[1];
          r_ie  <= wr_data[0];
        end
        if (regnum == REG_EPC) begin
          r_epc <= wr_data;
        end
      end
    end
  end

  // NOTE: rd_data gets its default before the case so that unmatched register
  // numbers cannot leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    case (regnum)
      REG_STATUS: rd_data = w_status;
      REG_CAUSE:  rd_data = w_cause;
      REG_EPC:    rd_data = r_epc;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
`timescale 1ns/1ps

module tb_cp0_interrupt_unit;

  localparam int NIRQ = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NIRQ-1:0] irq = '0;
  logic [4:0]      regnum = '0;
  logic [31:0]     wr_data = '0;
  logic            MTC0 = 1'b0;
  logic            ERET = 1'b0;
  logic            stall = 1'b0;
  logic [31:0]     next_pc = '0;
  logic [31:0]     rd_data;
  logic [31:0]     EPC;
  logic            TakenInterrupt;

  cp0_interrupt_unit #(.NIRQ(NIRQ)) dut (
    .clock          (clock),
    .reset          (reset),
    .irq            (irq),
    .regnum         (regnum),
    .wr_data        (wr_data),
    .MTC0           (MTC0),
    .ERET           (ERET),
    .stall          (stall),
    .next_pc        (next_pc),
    .rd_data        (rd_data),
    .EPC            (EPC),
    .TakenInterrupt (TakenInterrupt)
  );

  always #10 clock = ~clock;

  typedef struct {
    int          cyc;
    logic        take;
    logic [31:0] epc;
  } samp_t;

  samp_t exp_q[$];
  samp_t obs_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model of the architectural state
  logic [7:0]  m_samp, m_ip, m_im;
  logic        m_exl, m_ie;
  logic [31:0] m_epc;

  task automatic model_reset();
    m_samp = '0; m_ip = '0; m_im = '0;
    m_exl = 1'b0; m_ie = 1'b0; m_epc = '0;
  endtask

  // Called at a falling edge: drives one cycle, records expected and observed
  // take/EPC, advances the model across the rising edge, returns at next fall.
  task automatic drive_cycle(input logic [7:0] irq_v, input logic mtc0_v,
                             input logic [4:0] reg_v, input logic [31:0] wr_v,
                             input logic eret_v, input logic stall_v,
                             input logic [31:0] npc);
    samp_t e, o;
    irq = irq_v; MTC0 = mtc0_v; regnum = reg_v; wr_data = wr_v;
    ERET = eret_v; stall = stall_v; next_pc = npc;
    #1;
    e.cyc  = cyc;
    e.take = (|(m_ip & m_im)) & m_ie & ~m_exl & ~stall_v;
    e.epc  = m_epc;
    o.cyc  = cyc;
    o.take = TakenInterrupt;
    o.epc  = EPC;
    exp_q.push_back(e);
    obs_q.push_back(o);
    @(posedge clock);
    if (e.take) begin
      m_exl = 1'b1;
      m_epc = npc;
    end else if (!stall_v && eret_v) begin
      m_exl = 1'b0;
    end else if (!stall_v && mtc0_v) begin
      if (reg_v == 5'd12) begin
        m_im = wr_v[15:8]; m_exl = wr_v[1]; m_ie = wr_v[0];
      end
      if (reg_v == 5'd14) m_epc = wr_v;
    end
    m_ip   = m_samp;
    m_samp = irq_v;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input logic [7:0] irq_v, input logic [31:0] npc, input int n);
    for (int i = 0; i < n; i++) drive_cycle(irq_v, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, npc);
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b0;
    regnum = 5'd12; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_status got %h want %h", rd_data, 32'h0); end
    regnum = 5'd13; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_cause got %h want %h", rd_data, 32'h0); end
    regnum = 5'd14; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_epc_rd got %h want %h", rd_data, 32'h0); end
    total++; if (EPC !== 32'h0) begin bad++; $display("FAIL rst_epc got %h want %h", EPC, 32'h0); end
    total++; if (TakenInterrupt !== 1'b0) begin bad++; $display("FAIL rst_take got %b want 0", TakenInterrupt); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_take();
    samp_t e, o;
    int nt;
    drive_cycle(8'h00, 1'b1, 5'd12, 32'h0000_8001, 1'b0, 1'b0, 32'h0040_0020);
    idle(8'h80, 32'h0040_0020, 5);
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL take_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 1) begin bad++; $display("FAIL take_pulses got %0d want 1", nt); end
    total++; if (EPC !== 32'h0040_0020) begin bad++; $display("FAIL take_epc got %h want %h", EPC, 32'h0040_0020); end
    MTC0 = 1'b0; ERET = 1'b0; regnum = 5'd12; #1;
    total++; if (rd_data !== 32'h0000_8003) begin bad++; $display("FAIL take_status got %h want %h", rd_data, 32'h0000_8003); end
    regnum = 5'd13; #1;
    total++; if (rd_data !== 32'h0000_8000) begin bad++; $display("FAIL take_cause got %h want %h", rd_data, 32'h0000_8000); end
  endtask

  task automatic test_eret_retake();
    samp_t e, o;
    int nt;
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0040_0100);
    idle(8'h80, 32'h0040_0100, 3);
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL eret_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 1) begin bad++; $display("FAIL eret_pulses got %0d want 1", nt); end
    total++; if (EPC !== 32'h0040_0100) begin bad++; $display("FAIL eret_epc got %h want %h", EPC, 32'h0040_0100); end
  endtask

  task automatic test_mask();
    samp_t e, o;
    int nt, nt_before;
    // Drop the request, let IP drain, then leave the handler.
    idle(8'h00, 32'h0, 2);
    drive_cycle(8'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(8'h80, 1'b1, 5'd12, 32'h0000_4001, 1'b0, 1'b0, 32'h0040_0040);
    idle(8'h80, 32'h0040_0040, 3);
    nt_before = 0;
    foreach (obs_q[i]) if (obs_q[i].take === 1'b1) nt_before++;
    total++; if (nt_before !== 0) begin bad++; $display("FAIL mask_blocks got %0d takes want 0", nt_before); end
    drive_cycle(8'h80, 1'b1, 5'd12, 32'h0000_C001, 1'b0, 1'b0, 32'h0040_0040);
    idle(8'h80, 32'h0040_0040, 2);
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL mask_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 1) begin bad++; $display("FAIL mask_pulses got %0d want 1", nt); end
    MTC0 = 1'b0; ERET = 1'b0; regnum = 5'd12; #1;
    total++; if (rd_data !== 32'h0000_C003) begin bad++; $display("FAIL mask_status got %h want %h", rd_data, 32'h0000_C003); end
  endtask

  task automatic test_stall();
    samp_t e, o;
    int nt;
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    drive_cycle(8'h80, 1'b1, 5'd14, 32'h2222_2222, 1'b0, 1'b1, 32'h1111_1111);
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h1111_1111);
    total++; if (EPC !== 32'h0040_0040) begin bad++; $display("FAIL stall_epc_hold got %h want %h", EPC, 32'h0040_0040); end
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0040_0200);
    idle(8'h80, 32'h0040_0200, 1);
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL stall_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 1) begin bad++; $display("FAIL stall_pulses got %0d want 1", nt); end
    total++; if (EPC !== 32'h0040_0200) begin bad++; $display("FAIL stall_epc got %h want %h", EPC, 32'h0040_0200); end
  endtask

  task automatic test_priority();
    samp_t e, o;
    int nt;
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(8'h80, 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0040_0300);
    total++; if (EPC !== 32'h0040_0300) begin bad++; $display("FAIL prio_epc got %h want %h", EPC, 32'h0040_0300); end
    drive_cycle(8'h80, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    MTC0 = 1'b0; regnum = 5'd13; #1;
    total++; if (rd_data !== 32'h0000_8000) begin bad++; $display("FAIL cause_ro got %h want %h", rd_data, 32'h0000_8000); end
    regnum = 5'd9; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rd_other got %h want %h", rd_data, 32'h0); end
    drive_cycle(8'h80, 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    total++; if (EPC !== 32'hDEAD_BEEF) begin bad++; $display("FAIL epc_write got %h want %h", EPC, 32'hDEAD_BEEF); end
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL prio_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 1) begin bad++; $display("FAIL prio_pulses got %0d want 1", nt); end
  endtask

  task automatic test_back_to_back();
    samp_t e, o;
    int nt;
    // ERET and an MTC0 clearing Status coincide: ERET wins, IE stays set.
    drive_cycle(8'h80, 1'b1, 5'd12, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_cycle(8'h80, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0040_0400);
    idle(8'h00, 32'h0, 3);
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL b2b_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 1) begin bad++; $display("FAIL b2b_pulses got %0d want 1", nt); end
    total++; if (EPC !== 32'h0040_0400) begin bad++; $display("FAIL b2b_epc got %h want %h", EPC, 32'h0040_0400); end
    MTC0 = 1'b0; ERET = 1'b0; regnum = 5'd13; #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL ip_drop got %h want %h", rd_data, 32'h0); end
    regnum = 5'd12; #1;
    total++; if (rd_data !== 32'h0000_C003) begin bad++; $display("FAIL b2b_status got %h want %h", rd_data, 32'h0000_C003); end
  endtask

  task automatic test_reset_mid();
    samp_t e, o;
    int nt;
    idle(8'h80, 32'h0, 2);
    MTC0 = 1'b0; ERET = 1'b0; regnum = 5'd12; #1;
    total++; if (rd_data !== 32'h0000_C003) begin bad++; $display("FAIL mid_pre got %h want %h", rd_data, 32'h0000_C003); end
    #2 reset = 1'b0;
    #1;
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL mid_status got %h want %h", rd_data, 32'h0); end
    total++; if (EPC !== 32'h0) begin bad++; $display("FAIL mid_epc got %h want %h", EPC, 32'h0); end
    total++; if (TakenInterrupt !== 1'b0) begin bad++; $display("FAIL mid_take got %b want 0", TakenInterrupt); end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    idle(8'h80, 32'h0040_0500, 5);
    nt = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      if (o.take === 1'b1) nt++;
      total++;
      if (o.take !== e.take || o.epc !== e.epc) begin
        bad++; $display("FAIL mid_seq cyc=%0d got take=%b epc=%h want take=%b epc=%h", o.cyc, o.take, o.epc, e.take, e.epc);
      end
    end
    total++; if (nt !== 0) begin bad++; $display("FAIL mid_no_take got %0d want 0", nt); end
  endtask

  initial begin
    test_reset();
    test_take();
    test_eret_retake();
    test_mask();
    test_stall();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
